// File: rtl/testboard_sequencer.sv
// Gate-testboard sequencer: drives stimulus patterns to a gate under test, registers
// the results for the LEDs and compacts them into a MISR signature during auto sweeps.
module testboard_sequencer #(
    parameter int unsigned          NUM_IN        = 3,
    parameter int unsigned          NUM_RES       = 16,
    parameter int unsigned          SETTLE_CYCLES = 4,
    parameter logic [NUM_RES-1:0]   POLY          = 16'h002D,
    parameter logic [NUM_RES-1:0]   GOLDEN_SIG    = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mode_i,
    input  logic                start_i,
    input  logic [NUM_IN-1:0]   manual_pattern_i,
    input  logic [NUM_RES-1:0]  result_i,
    output logic [NUM_IN-1:0]   pattern_o,
    output logic [NUM_RES-1:0]  led_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic [NUM_RES-1:0]  signature_o
);

    localparam int unsigned        SettleW    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
    localparam logic [NUM_IN-1:0]  LastPat    = '1;

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StSettle,
        StSample,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_IN-1:0]    pattern_q, pattern_d;
    logic [NUM_RES-1:0]   sig_q, sig_d;
    logic [NUM_RES-1:0]   led_q;
    logic [SettleW-1:0]   settle_q, settle_d;
    logic [NUM_RES-1:0]   sig_next;

    // MISR step: shift left, fold the MSB back through POLY, inject the latched results.
    always_comb begin
        sig_next = {sig_q[NUM_RES-2:0], 1'b0} ^ led_q;
        if (sig_q[NUM_RES-1]) begin
            sig_next = sig_next ^ POLY;
        end
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        sig_d     = sig_q;
        settle_d  = settle_q;

        case (state_q)
            StIdle: begin
                if (mode_i) begin
                    if (start_i) begin
                        state_d   = StApply;
                        pattern_d = '0;
                        sig_d     = '0;
                    end
                end else begin
                    pattern_d = manual_pattern_i;
                end
            end
            StApply: begin
                state_d  = StSettle;
                settle_d = '0;
            end
            StSettle: begin
                if (settle_q == SettleLast) begin
                    state_d = StSample;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StSample: begin
                sig_d = sig_next;
                if (pattern_q == LastPat) begin
                    state_d = StDone;
                end else begin
                    pattern_d = pattern_q + 1'b1;
                    state_d   = StApply;
                end
            end
            StDone: begin
                // Pattern and signature stay frozen until the operator acts.
                if (mode_i) begin
                    if (start_i) begin
                        state_d   = StApply;
                        pattern_d = '0;
                        sig_d     = '0;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            pattern_q <= '0;
            sig_q     <= '0;
            led_q     <= '0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            sig_q     <= sig_d;
            led_q     <= result_i;
            settle_q  <= settle_d;
        end
    end

    assign pattern_o   = pattern_q;
    assign led_o       = led_q;
    assign signature_o = sig_q;
    assign busy_o      = (state_q == StApply) || (state_q == StSettle) || (state_q == StSample);
    assign done_o      = (state_q == StDone);
    assign pass_o      = (state_q == StDone) && (sig_q == GOLDEN_SIG);

endmodule

// File: tb/tb_testboard_sequencer.sv
// Directed bench for testboard_sequencer: three DUTs differing only in GOLDEN_SIG,
// checked every cycle against a sweep-offset model plus hand-computed literals.
module tb_testboard_sequencer;

    localparam int unsigned NI     = 2;
    localparam int unsigned NR     = 4;
    localparam int unsigned SC     = 2;
    localparam logic [3:0]  PL     = 4'b0011;
    localparam logic [3:0]  G0     = 4'b0000;
    localparam logic [3:0]  G1     = 4'b1111;
    localparam logic [3:0]  G2     = 4'b1110;
    localparam int          PER    = SC + 2;
    localparam int          NPAT   = 2 ** NI;
    localparam int          SWEEP  = NPAT * PER;

    logic          clk = 1'b0;
    logic          rst, mode, start;
    logic [NI-1:0] manual;
    logic [NR-1:0] result;

    logic [NI-1:0] pat0, pat1, pat2;
    logic [NR-1:0] led0, led1, led2;
    logic [NR-1:0] sig0, sig1, sig2;
    logic          busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    testboard_sequencer #(.NUM_IN(NI), .NUM_RES(NR), .SETTLE_CYCLES(SC), .POLY(PL),
                          .GOLDEN_SIG(G0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .start_i(start),
        .manual_pattern_i(manual), .result_i(result), .pattern_o(pat0), .led_o(led0),
        .busy_o(busy0), .done_o(done0), .pass_o(pass0), .signature_o(sig0));

    testboard_sequencer #(.NUM_IN(NI), .NUM_RES(NR), .SETTLE_CYCLES(SC), .POLY(PL),
                          .GOLDEN_SIG(G1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .start_i(start),
        .manual_pattern_i(manual), .result_i(result), .pattern_o(pat1), .led_o(led1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .signature_o(sig1));

    testboard_sequencer #(.NUM_IN(NI), .NUM_RES(NR), .SETTLE_CYCLES(SC), .POLY(PL),
                          .GOLDEN_SIG(G2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .start_i(start),
        .manual_pattern_i(manual), .result_i(result), .pattern_o(pat2), .led_o(led2),
        .busy_o(busy2), .done_o(done2), .pass_o(pass2), .signature_o(sig2));

    // Model: a sweep is tracked only as "cycles elapsed since start"; everything else
    // follows arithmetically from that offset.
    bit            m_active, m_done;
    int            m_k;
    logic [NI-1:0] m_pat;
    logic [NR-1:0] m_sig, m_led;

    function automatic logic [NR-1:0] misr(input logic [NR-1:0] s, input logic [NR-1:0] d);
        logic [NR-1:0] r;
        r = (s << 1) ^ d;
        if (s[NR-1]) r = r ^ PL;
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_k      <= 0;
            m_pat    <= '0;
            m_sig    <= '0;
            m_led    <= '0;
        end else begin
            m_led <= result;
            if (m_active) begin
                if (m_k % PER == PER - 1) begin
                    m_sig <= misr(m_sig, m_led);
                    if (m_k == SWEEP - 1) begin
                        m_active <= 1'b0;
                        m_done   <= 1'b1;
                    end else begin
                        m_pat <= m_pat + 1'b1;
                    end
                end
                m_k <= m_k + 1;
            end else if (mode && start) begin
                m_active <= 1'b1;
                m_done   <= 1'b0;
                m_k      <= 0;
                m_pat    <= '0;
                m_sig    <= '0;
            end else if (!mode) begin
                if (m_done) m_done <= 1'b0;
                else        m_pat  <= manual;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("mdl_pattern", 32'(pat0), 32'(m_pat));
            check("mdl_led", 32'(led0), 32'(m_led));
            check("mdl_sig", 32'(sig0), 32'(m_sig));
            check("mdl_busy", 32'(busy0), 32'(m_active));
            check("mdl_done", 32'(done0), 32'(m_done));
            check("mdl_pass0", 32'(pass0), 32'(m_done && (m_sig == G0)));
            check("mdl_pass1", 32'(pass1), 32'(m_done && (m_sig == G1)));
            check("mdl_pass2", 32'(pass2), 32'(m_done && (m_sig == G2)));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full sweep from IDLE or DONE; cycle c = number of edges since start was sampled.
    task automatic run_sweep(input bit res_one, input bit start_pulses, input bit mode_glitch);
        logic [3:0] sig_tab [4];
        sig_tab[0] = 4'b0001;
        sig_tab[1] = 4'b0011;
        sig_tab[2] = 4'b0111;
        sig_tab[3] = 4'b1111;
        mode  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= SWEEP + 1; c++) begin
            if (c <= SWEEP) begin
                check("lit_pattern", 32'(pat0), 32'((c - 1) / 4));
                check("lit_pass_busy", 32'({pass0, pass1, pass2}), 32'(0));
            end
            check("lit_busy", 32'(busy0), 32'(c <= 16));
            check("lit_done", 32'(done0), 32'(c == 17));
            if (c > 1 && c % 4 == 1)
                check("lit_sig", 32'(sig0), res_one ? 32'(sig_tab[c / 4 - 1]) : 32'(0));
            start = start_pulses && (c == 5 || c == 9);
            if (mode_glitch) mode = !(c >= 6 && c < 12);
            if (c <= SWEEP) tick();
        end
        start = 1'b0;
        mode  = 1'b1;
        check("lit_pass0", 32'(pass0), 32'(!res_one));
        check("lit_pass1", 32'(pass1), 32'(res_one));
        check("lit_pass2", 32'(pass2), 32'(0));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        mode   = 1'b1;
        start  = 1'b0;
        manual = '0;
        result = '0;
        @(negedge clk);
        tick();
        cmp_en = 1'b1;
        check("rst_pattern", 32'(pat0), 32'(0));
        check("rst_sig", 32'(sig0), 32'(0));
        check("rst_led", 32'(led0), 32'(0));
        check("rst_flags", 32'({busy0, done0, pass0}), 32'(0));

        // Reset wins over a simultaneous start.
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_prio_busy", 32'(busy0), 32'(0));
        tick();
        check("rst_prio_idle", 32'(busy0), 32'(0));

        run_sweep(1'b0, 1'b0, 1'b0);
        result = 4'b0001;
        run_sweep(1'b1, 1'b0, 1'b0);
        run_sweep(1'b1, 1'b1, 1'b0);

        // Reset during SETTLE of pattern 2.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("mid_pattern", 32'(pat0), 32'(2));
        check("mid_busy", 32'(busy0), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy0), 32'(0));
        check("mid_rst_pattern", 32'(pat0), 32'(0));
        check("mid_rst_sig", 32'(sig0), 32'(0));
        for (int i = 0; i < 20; i++) begin
            check("mid_no_done", 32'(done0), 32'(0));
            tick();
        end
        run_sweep(1'b1, 1'b0, 1'b0);

        // Manual mode: DONE drops to IDLE, then the DIP pattern is registered.
        mode   = 1'b0;
        manual = 2'b10;
        result = 4'b1010;
        tick();
        check("man_done_clr", 32'(done0), 32'(0));
        tick();
        check("man_pattern", 32'(pat0), 32'(2));
        check("man_led", 32'(led0), 32'(4'b1010));
        check("man_busy", 32'(busy0), 32'(0));
        result = 4'b0101;
        tick();
        check("man_led2", 32'(led0), 32'(4'b0101));

        result = 4'b0001;
        run_sweep(1'b1, 1'b0, 1'b1);
        run_sweep(1'b1, 1'b0, 1'b0);
        mode = 1'b0;
        tick();
        check("ret_idle_flags", 32'({busy0, done0, pass1}), 32'(0));
        tick();
        check("ret_idle_pattern", 32'(pat0), 32'(2));

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
